// File: rtl/lsu_mem_master.sv
// Load/store initiator for a 32-bit byte-write-enable data RAM.
// Splits word-crossing accesses into two RAM cycles and extends load data.
module lsu_mem_master #(
   parameter int unsigned ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       resp_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_data_in,
   output logic              mem_we,
   output logic [3:0]        mem_byte_we,
   input  logic [31:0]       mem_data_out
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StAcc0 = 3'd1;
   localparam logic [2:0] StAcc1 = 3'd2;
   localparam logic [2:0] StWait = 3'd3;
   localparam logic [2:0] StResp = 3'd4;

   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         2'b10:   size_mask = 4'b1111;
         default: size_mask = 4'b0000;
      endcase
   endfunction

   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (sz)
         2'b00:   size_bytes = 3'd1;
         2'b01:   size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

   function automatic logic is_legal(input logic we, input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010: is_legal = 1'b1;
         3'b100, 3'b101:         is_legal = ~we;
         default:                is_legal = 1'b0;
      endcase
   endfunction

   logic [2:0]        state_q;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              err_q;
   logic [31:0]       part_a_q;
   logic [31:0]       result_q;
   logic [ADDR_W-1:0] mem_address_q;
   logic [31:0]       mem_data_in_q;
   logic              mem_we_q;
   logic [3:0]        mem_byte_we_q;

   logic [1:0]        off;
   logic              split;
   logic [2:0]        hi_bytes;
   logic [5:0]        hi_shift;
   logic [31:0]       lo_keep;
   logic [ADDR_W-3:0] word_inc;
   logic [31:0]       ext;

   assign off      = addr_q[1:0];
   assign split    = ({1'b0, off} + size_bytes(funct3_q[1:0])) > 3'd4;
   // Bytes of the access that fall in the first word; only meaningful when split.
   assign hi_bytes = 3'd4 - {1'b0, off};
   assign hi_shift = {hi_bytes, 3'b000};
   assign lo_keep  = 32'hFFFF_FFFF >> {off, 3'b000};
   assign word_inc = addr_q[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1};

   always_comb begin
      ext = result_q;
      case (funct3_q)
         3'b000:  ext = {{24{result_q[7]}}, result_q[7:0]};
         3'b001:  ext = {{16{result_q[15]}}, result_q[15:0]};
         3'b100:  ext = {24'h0, result_q[7:0]};
         3'b101:  ext = {16'h0, result_q[15:0]};
         default: ext = result_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         we_q          <= 1'b0;
         funct3_q      <= 3'b000;
         addr_q        <= '0;
         wdata_q       <= 32'h0;
         err_q         <= 1'b0;
         part_a_q      <= 32'h0;
         result_q      <= 32'h0;
         mem_address_q <= '0;
         mem_data_in_q <= 32'h0;
         mem_we_q      <= 1'b0;
         mem_byte_we_q <= 4'h0;
      end else begin
         mem_we_q      <= 1'b0;
         mem_byte_we_q <= 4'h0;
         case (state_q)
            StIdle: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  result_q <= 32'h0;
                  if (!is_legal(req_we, req_funct3)) begin
                     err_q   <= 1'b1;
                     state_q <= StResp;
                  end else begin
                     err_q         <= 1'b0;
                     mem_address_q <= req_addr;
                     mem_byte_we_q <= size_mask(req_funct3[1:0]);
                     mem_data_in_q <= req_wdata;
                     mem_we_q      <= req_we;
                     state_q       <= StAcc0;
                  end
               end
            end
            StAcc0: begin
               if (split) begin
                  mem_address_q <= {word_inc, 2'b00};
                  mem_byte_we_q <= size_mask(funct3_q[1:0]) >> hi_bytes;
                  mem_data_in_q <= wdata_q >> hi_shift;
                  mem_we_q      <= we_q;
                  state_q       <= StAcc1;
               end else if (we_q) begin
                  state_q <= StResp;
               end else begin
                  state_q <= StWait;
               end
            end
            StAcc1: begin
               part_a_q <= mem_data_out;
               state_q  <= we_q ? StResp : StWait;
            end
            StWait: begin
               result_q <= split ? ((part_a_q & lo_keep) | (mem_data_out << hi_shift))
                                 : mem_data_out;
               state_q  <= StResp;
            end
            StResp:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready   = (state_q == StIdle);
   assign resp_valid  = (state_q == StResp);
   assign resp_err    = (state_q == StResp) & err_q;
   assign resp_rdata  = ((state_q == StResp) && !err_q && !we_q) ? ext : 32'h0;
   assign mem_address = mem_address_q;
   assign mem_data_in = mem_data_in_q;
   assign mem_we      = mem_we_q;
   assign mem_byte_we = mem_byte_we_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized scoreboard bench for lsu_mem_master against a byte-array memory model
// and a word-bounded, lane-shifting RAM model.
module tb_lsu_mem_master;

   localparam int unsigned AW    = 14;
   localparam int          MEMSZ = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_funct3;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic          resp_err;
   logic [31:0]   resp_rdata;
   logic [AW-1:0] mem_address;
   logic [31:0]   mem_data_in;
   logic          mem_we;
   logic [3:0]    mem_byte_we;
   logic [31:0]   mem_data_out;

   lsu_mem_master #(.ADDR_W(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_err     (resp_err),
      .resp_rdata   (resp_rdata),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_we       (mem_we),
      .mem_byte_we  (mem_byte_we),
      .mem_data_out (mem_data_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   typedef struct {
      int unsigned   cyc;
      logic [AW-1:0] addr;
      logic [3:0]    bwe;
      logic [31:0]   data;
      logic          we;
   } bus_t;

   rsp_t        rsp_q[$];
   bus_t        bus_q[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   int unsigned last_resp = 0;
   bit          mon_en = 1'b0;
   bit          done = 1'b0;
   logic [7:0]  ref_mem [MEMSZ];

   function automatic logic [7:0] init_byte(input int a);
      return 8'(a * 37 + 11) ^ 8'(a >> 8);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: lanes beyond the end of the addressed word are not accessed.
   logic [7:0] ram [MEMSZ];
   logic       ram_ready = 1'b0;
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < MEMSZ; i++) ram[i] <= init_byte(i);
         ram_ready <= 1'b1;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (i < 4 - int'(mem_address[1:0])) begin
               mem_data_out[8*i +: 8] <= ram[int'(mem_address) + i];
               if (mem_we && mem_byte_we[i])
                  ram[int'(mem_address) + i] <= mem_data_in[8*i +: 8];
            end else begin
               mem_data_out[8*i +: 8] <= 8'($urandom);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int sz(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
      logic [31:0] raw = 32'h0;
      for (int i = 0; i < sz(f3); i++) raw[8*i +: 8] = ref_mem[(a + i) % MEMSZ];
      case (f3)
         3'b000:  return {{24{raw[7]}}, raw[7:0]};
         3'b001:  return {{16{raw[15]}}, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   task automatic issue(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                        input logic [31:0] wd, input bit exp_resp);
      int unsigned t;
      int          guard;
      int          off;
      int          n;
      int          lat;
      bit          legal;
      bit          split;
      logic [3:0]  m;
      rsp_t        r;
      bus_t        b;
      legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      off   = int'(a[1:0]);
      n     = sz(f3);
      split = legal && (off + n > 4);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      guard = 0;
      while (!req_ready && guard < 30) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         check("accept_timeout", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      t = cyc;
      if (last_resp != 0) check("b2b_accept", t, last_resp + 1);
      lat = !legal ? 1 : we ? (split ? 3 : 2) : (split ? 4 : 3);
      last_resp = t + lat;
      if (legal) begin
         m = (n == 1) ? 4'h1 : (n == 2) ? 4'h3 : 4'hF;
         b.cyc = t + 1; b.addr = a; b.bwe = m; b.data = wd; b.we = we;
         bus_q.push_back(b);
         if (split) begin
            b.cyc  = t + 2;
            b.addr = a + AW'(4 - off);
            b.bwe  = m >> (4 - off);
            b.data = wd >> (8 * (4 - off));
            bus_q.push_back(b);
         end
      end
      if (exp_resp) begin
         r.cyc   = t + lat;
         r.err   = !legal;
         r.rdata = (!legal || we) ? 32'h0 : ref_load(f3, int'(a));
         rsp_q.push_back(r);
      end
      if (legal && we)
         for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % MEMSZ] = wd[8*i +: 8];
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = AW'($urandom);
   endtask

   initial begin
      rsp_t r;
      bus_t b;
      int   guard;
      logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      for (int i = 0; i < MEMSZ; i++) ref_mem[i] = init_byte(i);
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = '0; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_byte_we", 32'(mem_byte_we), 32'd0);
      check("rst_mem_address", 32'(mem_address), 32'd0);
      check("rst_mem_data_in", mem_data_in, 32'h0);
      rst = 1'b0;
      mon_en = 1'b1;
      fork
         begin
            issue(1'b1, 3'b010, 14'h0010, 32'hDEAD_BEEF, 1'b1);
            issue(1'b0, 3'b010, 14'h0010, 32'h0, 1'b1);
            issue(1'b1, 3'b000, 14'h0013, 32'h0000_00A5, 1'b1);
            issue(1'b0, 3'b000, 14'h0013, 32'h0, 1'b1);
            issue(1'b0, 3'b100, 14'h0013, 32'h0, 1'b1);
            issue(1'b0, 3'b001, 14'h0012, 32'h0, 1'b1);
            issue(1'b1, 3'b010, 14'h0006, 32'h1122_3344, 1'b1);
            issue(1'b0, 3'b010, 14'h0006, 32'h0, 1'b1);
            issue(1'b1, 3'b001, 14'h3FFF, 32'h0000_BEEF, 1'b1);
            issue(1'b0, 3'b101, 14'h3FFF, 32'h0, 1'b1);
            issue(1'b0, 3'b011, 14'h0020, 32'h0, 1'b1);
            issue(1'b1, 3'b100, 14'h0024, 32'h5555_5555, 1'b1);
            // Reset during the second RAM cycle of a split store.
            issue(1'b1, 3'b010, 14'h0106, 32'hCAFE_F00D, 1'b0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("midrst_req_ready", 32'(req_ready), 32'd1);
            check("midrst_mem_we", 32'(mem_we), 32'd0);
            check("midrst_resp_valid", 32'(resp_valid), 32'd0);
            rst = 1'b0;
            last_resp = 0;
            repeat (4) @(negedge clk);
            issue(1'b0, 3'b010, 14'h0106, 32'h0, 1'b1);
            for (int k = 0; k < 300; k++) begin
               logic          we;
               logic [2:0]    f3;
               logic [AW-1:0] a;
               we = 1'($urandom);
               if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
               else if (we)                   f3 = 3'($urandom_range(0, 2));
               else                           f3 = ld_f3[$urandom_range(0, 4)];
               if ($urandom_range(0, 3) == 0) a = 14'h3FF8 + AW'($urandom_range(0, 7));
               else                           a = AW'($urandom_range(0, 63));
               issue(we, f3, a, $urandom, 1'b1);
            end
            guard = 0;
            while ((rsp_q.size() != 0 || bus_q.size() != 0) && guard < 20) begin
               @(negedge clk);
               guard++;
            end
            check("drain_resp", 32'(rsp_q.size()), 32'd0);
            check("drain_bus", 32'(bus_q.size()), 32'd0);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               if (mon_en && resp_valid) begin
                  if (rsp_q.size() == 0) begin
                     check("unexpected_resp", 32'(resp_valid), 32'd0);
                  end else begin
                     r = rsp_q.pop_front();
                     check("resp_cycle", cyc, r.cyc);
                     check("resp_err", 32'(resp_err), 32'(r.err));
                     check("resp_rdata", resp_rdata, r.rdata);
                  end
               end
               if (mon_en && (mem_we || mem_byte_we != 4'h0)) begin
                  if (bus_q.size() == 0) begin
                     check("unexpected_mem", {27'h0, mem_we, mem_byte_we}, 32'h0);
                  end else begin
                     b = bus_q.pop_front();
                     check("mem_cycle", cyc, b.cyc);
                     check("mem_address", 32'(mem_address), 32'(b.addr));
                     check("mem_byte_we", 32'(mem_byte_we), 32'(b.bwe));
                     check("mem_data_in", mem_data_in, b.data);
                     check("mem_we", 32'(mem_we), 32'(b.we));
                  end
               end
            end
         end
      join
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
